// File: rtl/embedded_system_nios2_qsys_0_div_cell_if.sv
// Request/result bundle between the Nios II M stage and the iterative divide cell.
// The remainder signal exists only when NIOS_DIV_REMAINDER_EN is defined.
interface embedded_system_nios2_qsys_0_div_cell_if #(
  parameter int unsigned DATA_W = 32
);
  logic              M_div_start;
  logic              M_div_signed;
  logic [DATA_W-1:0] M_div_src1;
  logic [DATA_W-1:0] M_div_src2;
  logic              M_div_busy;
  logic              M_div_done;
  logic [DATA_W-1:0] M_div_cell_result;
  logic              M_div_by_zero;
`ifdef NIOS_DIV_REMAINDER_EN
  logic [DATA_W-1:0] M_div_cell_remainder;

  modport master (
    output M_div_start, M_div_signed, M_div_src1, M_div_src2,
    input  M_div_busy, M_div_done, M_div_cell_result, M_div_by_zero, M_div_cell_remainder
  );

  modport slave (
    input  M_div_start, M_div_signed, M_div_src1, M_div_src2,
    output M_div_busy, M_div_done, M_div_cell_result, M_div_by_zero, M_div_cell_remainder
  );
`else
  modport master (
    output M_div_start, M_div_signed, M_div_src1, M_div_src2,
    input  M_div_busy, M_div_done, M_div_cell_result, M_div_by_zero
  );

  modport slave (
    input  M_div_start, M_div_signed, M_div_src1, M_div_src2,
    output M_div_busy, M_div_done, M_div_cell_result, M_div_by_zero
  );
`endif
endinterface

// File: rtl/embedded_system_nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider for Nios II div/divu, one quotient bit per cycle.
// Define NIOS_DIV_REMAINDER_EN to export the remainder on the interface.
module embedded_system_nios2_qsys_0_div_cell #(
  parameter int unsigned DATA_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  embedded_system_nios2_qsys_0_div_cell_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q;
  logic              signed_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] dvd_q;   // dividend shifts out at the top, quotient shifts in at the bottom
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] rem_q;
  logic              q_neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] result_q;
  logic              by_zero_q;
`ifdef NIOS_DIV_REMAINDER_EN
  logic              r_neg_q;
  logic [DATA_W-1:0] remainder_q;
`endif

  // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;
  assign mag1 = (signed_q && src1_q[DATA_W-1]) ? -src1_q : src1_q;
  assign mag2 = (signed_q && src2_q[DATA_W-1]) ? -src2_q : src2_q;

  // Restoring step: the shifted partial remainder is always below 2*|dvs|.
  logic [DATA_W:0]   shifted;
  logic              trial_ok;
  logic [DATA_W-1:0] rem_sub;
  assign shifted  = {rem_q, dvd_q[DATA_W-1]};
  assign trial_ok = (shifted >= {1'b0, dvs_q});
  assign rem_sub  = shifted[DATA_W-1:0] - dvs_q;

  logic [DATA_W-1:0] q_fix;
  logic              is_zero;
  logic              is_ovf;
  assign q_fix   = q_neg_q ? -dvd_q : dvd_q;
  assign is_zero = (src2_q == '0);
  assign is_ovf  = signed_q && (src1_q == MIN_NEG) && (src2_q == '1);

`ifdef NIOS_DIV_REMAINDER_EN
  logic [DATA_W-1:0] r_fix;
  assign r_fix = r_neg_q ? -rem_q : rem_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      signed_q    <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      by_zero_q   <= 1'b0;
`ifdef NIOS_DIV_REMAINDER_EN
      r_neg_q     <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.M_div_start) begin
            signed_q <= bus.M_div_signed;
            src1_q   <= bus.M_div_src1;
            src2_q   <= bus.M_div_src2;
            busy_q   <= 1'b1;
            state_q  <= S_SETUP;
          end
        end
        S_SETUP: begin
          dvd_q   <= mag1;
          dvs_q   <= mag2;
          rem_q   <= '0;
          q_neg_q <= signed_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
`ifdef NIOS_DIV_REMAINDER_EN
          r_neg_q <= signed_q & src1_q[DATA_W-1];
`endif
          cnt_q   <= CNT_W'(DATA_W - 1);
          state_q <= S_CALC;
        end
        S_CALC: begin
          rem_q <= trial_ok ? rem_sub : shifted[DATA_W-1:0];
          dvd_q <= {dvd_q[DATA_W-2:0], trial_ok};
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_FIX: begin
          // Special cases take precedence over the computed magnitudes.
          if (is_zero) begin
            result_q    <= '1;
            by_zero_q   <= 1'b1;
`ifdef NIOS_DIV_REMAINDER_EN
            remainder_q <= src1_q;
`endif
          end else if (is_ovf) begin
            result_q    <= MIN_NEG;
            by_zero_q   <= 1'b0;
`ifdef NIOS_DIV_REMAINDER_EN
            remainder_q <= '0;
`endif
          end else begin
            result_q    <= q_fix;
            by_zero_q   <= 1'b0;
`ifdef NIOS_DIV_REMAINDER_EN
            remainder_q <= r_fix;
`endif
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.M_div_busy        = busy_q;
  assign bus.M_div_done        = done_q;
  assign bus.M_div_cell_result = result_q;
  assign bus.M_div_by_zero     = by_zero_q;
`ifdef NIOS_DIV_REMAINDER_EN
  assign bus.M_div_cell_remainder = remainder_q;
`endif

endmodule
